// File: rtl/line_encoder_serializer_pkg.sv
// Shared definitions for the line encoder/serializer: FSM encodings,
// default geometry and the helper that turns a line count into a code width.
package le_pkg;

  localparam int DEFAULT_N_LINES = 4;

  // FSM state encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  typedef logic [0:0] state_t;

  // Width of a binary code able to index n lines (at least one bit)
  function automatic int code_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_encoder_serializer_if.sv
// Bundle of the input-vector and output-code handshakes.
// Handshake rule (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high; once valid is raised, it and its payload
// stay stable until that transfer happens.
interface line_encoder_serializer_if
  import le_pkg::*;
#(
  parameter int N_LINES = DEFAULT_N_LINES
);
  localparam int CODE_W = code_w(N_LINES);

  logic               in_valid;
  logic               in_ready;
  logic [N_LINES-1:0] in_lines;
  logic               out_valid;
  logic               out_ready;
  logic [CODE_W-1:0]  out_code;
  logic               out_last;
  logic               empty_err;

  // Environment side: offers vectors, consumes codes
  modport master (
    output in_valid, in_lines, out_ready,
    input  in_ready, out_valid, out_code, out_last, empty_err
  );

  // Block side
  modport slave (
    input  in_valid, in_lines, out_ready,
    output in_ready, out_valid, out_code, out_last, empty_err
  );

endinterface

// File: rtl/line_encoder_serializer_prio_enc.sv
// Combinational priority encoder: index of the highest set bit, plus flags
// for "any bit set" and "exactly one bit set".
module prio_enc
  import le_pkg::*;
#(
  parameter int N_LINES = DEFAULT_N_LINES,
  parameter int CODE_W  = code_w(N_LINES)
) (
  input  logic [N_LINES-1:0] vec_i,
  output logic [CODE_W-1:0]  code_o,
  output logic               any_o,
  output logic               single_o
);

  // Scan upward so the highest set bit is the last one to win
  always_comb begin
    code_o = '0;
    for (int i = 0; i < N_LINES; i++) begin
      if (vec_i[i]) code_o = CODE_W'(i);
    end
  end

  assign any_o    = |vec_i;
  // Clearing the lowest set bit leaves zero only for a single-bit vector
  assign single_o = any_o && ((vec_i & (vec_i - N_LINES'(1))) == '0);

endmodule

// File: rtl/line_encoder_serializer.sv
// Captures a vector of decoded select lines and emits the binary code of each
// asserted line, highest index first, one code per output handshake.
// All outputs come from registered state (state_q, pending_q, empty_err_q).
module line_encoder_serializer
  import le_pkg::*;
#(
  parameter int N_LINES = DEFAULT_N_LINES
) (
  input  logic                      clk,
  input  logic                      rst,
  line_encoder_serializer_if.slave  bus,
  output state_t                    state_o
);

  localparam int CODE_W = code_w(N_LINES);

  state_t             state_q, state_d;
  logic [N_LINES-1:0] pending_q, pending_d;
  logic               empty_err_q, empty_err_d;

  logic [CODE_W-1:0]  enc_code;
  logic               enc_any;
  logic               enc_single;

  prio_enc #(
    .N_LINES (N_LINES),
    .CODE_W  (CODE_W)
  ) u_prio_enc (
    .vec_i    (pending_q),
    .code_o   (enc_code),
    .any_o    (enc_any),
    .single_o (enc_single)
  );

  // Next-state: capture in IDLE, retire one line per handshake in EMIT
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    empty_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (|bus.in_lines) begin
            pending_d = bus.in_lines;
            state_d   = ST_EMIT;
          end else begin
            empty_err_d = 1'b1;
          end
        end
      end
      default: begin
        if (bus.out_ready) begin
          pending_d[enc_code] = 1'b0;
          // enc_any guards against ever sitting in EMIT with nothing pending
          if (enc_single || !enc_any) state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State registers with synchronous reset that discards any pending work
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      empty_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      empty_err_q <= empty_err_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_EMIT);
  assign bus.out_code  = enc_code;
  assign bus.out_last  = enc_single;
  assign bus.empty_err = empty_err_q;
  assign state_o       = state_q;

endmodule
